// File: rtl/reaction_scorer.sv
// Reaction timer: measures press delay in ms after the stimulus and keeps the best score.
// Latency: press pulses appear 3 cycles after btn_n falls; high-score update one cycle after state-3 entry.
// Backpressure: none; inputs are sampled every cycle and pulses are never stalled.
module reaction_scorer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int MAX_MS = 999
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [1:0] state,
    input  logic       btn_n,
    input  logic       clr_hs,
    output logic       press_done,
    output logic       false_start,
    output logic       timeout,
    output logic [9:0] last_time,
    output logic [9:0] best_time,
    output logic       hs_valid,
    output logic       new_hs
);

    localparam int PRESC = CLK_HZ / 1000;
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [9:0] MAX_T = 10'(MAX_MS);

    logic [PW-1:0] presc;
    logic [9:0]    ms_cnt;
    logic          btn_meta;
    logic          btn_sync;
    logic          btn_prev;
    logic [1:0]    prev_state;
    logic          captured;
    logic          fs_flag;
    logic          to_flag;
    logic          press;
    logic          enter;
    logic          eval_ok;

    always_comb begin
        press   = btn_prev & ~btn_sync;
        enter   = (state != prev_state);
        eval_ok = (state == 2'd3) && enter && captured && !fs_flag && !to_flag &&
                  (!hs_valid || (last_time < best_time));
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_prev    <= 1'b0;
            prev_state  <= 2'd0;
            presc       <= '0;
            ms_cnt      <= '0;
            captured    <= 1'b0;
            fs_flag     <= 1'b0;
            to_flag     <= 1'b0;
            press_done  <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            last_time   <= '0;
            best_time   <= '0;
            hs_valid    <= 1'b0;
            new_hs      <= 1'b0;
        end else begin
            btn_meta    <= btn_n;
            btn_sync    <= btn_meta;
            btn_prev    <= btn_sync;
            prev_state  <= state;
            press_done  <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;

            if (state == 2'd1) begin
                if (enter) begin
                    captured <= 1'b0;
                    to_flag  <= 1'b0;
                end
                if (press) begin
                    false_start <= 1'b1;
                    fs_flag     <= 1'b1;
                end else if (enter) begin
                    fs_flag <= 1'b0;
                end
            end

            // A press in the saturation cycle takes priority and records MAX_MS.
            if (state == 2'd2) begin
                if (enter) begin
                    presc  <= '0;
                    ms_cnt <= '0;
                end else if (!captured) begin
                    if (press) begin
                        last_time  <= ms_cnt;
                        press_done <= 1'b1;
                        captured   <= 1'b1;
                    end else if (ms_cnt == MAX_T) begin
                        last_time <= MAX_T;
                        timeout   <= 1'b1;
                        to_flag   <= 1'b1;
                        captured  <= 1'b1;
                    end else if (presc == PRESC_LAST) begin
                        presc  <= '0;
                        ms_cnt <= ms_cnt + 10'd1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
            end

            if (state != 2'd3)
                new_hs <= 1'b0;
            if (eval_ok) begin
                best_time <= last_time;
                hs_valid  <= 1'b1;
                new_hs    <= 1'b1;
            end
            if (clr_hs) begin
                best_time <= '0;
                hs_valid  <= 1'b0;
                new_hs    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reaction_scorer.sv
// Bench for reaction_scorer: directed rounds with hand-computed results, then randomized rounds and chaos,
// all compared every cycle against a behavioural model based on elapsed cycles since stimulus.
module tb_reaction_scorer;

    localparam int CLK_HZ = 4000;
    localparam int MAX_MS = 20;
    localparam int P = CLK_HZ / 1000;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic [1:0] state = 2'd0;
    logic       btn_n = 1'b1;
    logic       clr_hs = 1'b0;
    logic       press_done, false_start, timeout, hs_valid, new_hs;
    logic [9:0] last_time, best_time;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int pd_cnt = 0, fs_cnt = 0, to_cnt = 0;

    reaction_scorer #(.CLK_HZ(CLK_HZ), .MAX_MS(MAX_MS)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .state(state), .btn_n(btn_n), .clr_hs(clr_hs),
        .press_done(press_done), .false_start(false_start), .timeout(timeout),
        .last_time(last_time), .best_time(best_time), .hs_valid(hs_valid), .new_hs(new_hs)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: button samples per edge, elapsed cycles since stimulus.
    bit m_hist[1:3];
    int m_prev = 0, k2 = 0;
    bit m_cap, m_fsf, m_tof;
    bit m_pd, m_fs, m_to, m_hv, m_nhs;
    int m_last = 0, m_best = 0;

    always @(posedge iCLK) begin
        bit press, enter;
        int ms;
        if (!iRST_N) begin
            m_hist = '{0, 0, 0};
            m_prev = 0; k2 = 0;
            {m_cap, m_fsf, m_tof, m_pd, m_fs, m_to, m_hv, m_nhs} = '0;
            m_last = 0; m_best = 0;
        end else begin
            press = !m_hist[2] && m_hist[3];
            enter = (int'(state) != m_prev);
            m_pd = 0; m_fs = 0; m_to = 0;
            if (state == 1) begin
                if (enter) begin m_cap = 0; m_tof = 0; end
                if (press) begin m_fs = 1; m_fsf = 1; end
                else if (enter) m_fsf = 0;
            end
            if (state == 2) begin
                if (enter) k2 = 0;
                else begin
                    k2++;
                    if (!m_cap) begin
                        ms = (k2 - 1) / P;
                        if (ms > MAX_MS) ms = MAX_MS;
                        if (press) begin m_last = ms; m_pd = 1; m_cap = 1; end
                        else if (ms == MAX_MS) begin m_last = MAX_MS; m_to = 1; m_tof = 1; m_cap = 1; end
                    end
                end
            end
            if (state != 3) m_nhs = 0;
            if (state == 3 && enter && m_cap && !m_fsf && !m_tof && (!m_hv || m_last < m_best)) begin
                m_best = m_last; m_hv = 1; m_nhs = 1;
            end
            if (clr_hs) begin m_best = 0; m_hv = 0; m_nhs = 0; end
            m_prev = int'(state);
            m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = btn_n;
        end
    end

    always @(negedge iCLK) begin
        if (cmp_en) begin
            check("press_done", 32'(press_done), 32'(m_pd));
            check("false_start", 32'(false_start), 32'(m_fs));
            check("timeout", 32'(timeout), 32'(m_to));
            check("last_time", 32'(last_time), 32'(m_last));
            check("best_time", 32'(best_time), 32'(m_best));
            check("hs_valid", 32'(hs_valid), 32'(m_hv));
            check("new_hs", 32'(new_hs), 32'(m_nhs));
        end
        if (press_done === 1'b1) pd_cnt++;
        if (false_start === 1'b1) fs_cnt++;
        if (timeout === 1'b1) to_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    // One round: state 1, optional false start, state 2 with a press d cycles after entry, then state 3.
    task automatic round(input int d, input bit fs_press, input bit clr_eval, input int hold2,
                         input bit lit, input int e_last, input int e_best, input int e_hv,
                         input int e_nhs, input int e_pd, input int e_fs, input int e_to);
        int pd0, fs0, to0, lat;
        pd0 = pd_cnt; fs0 = fs_cnt; to0 = to_cnt; lat = -1;
        state = 2'd1;
        tick(6);
        if (fs_press) begin
            btn_n = 1'b0; tick(3); btn_n = 1'b1; tick(4);
        end
        state = 2'd2;
        for (int i = 0; i < hold2; i++) begin
            btn_n = !(i >= d && i < d + 3);
            tick(1);
            if (press_done === 1'b1 && lat < 0) lat = i + 1 - d;
        end
        btn_n = 1'b1;
        state = 2'd3;
        clr_hs = clr_eval;
        tick(1);
        clr_hs = 1'b0;
        tick(6);
        if (lit) begin
            check("round_last", 32'(last_time), 32'(e_last));
            check("round_best", 32'(best_time), 32'(e_best));
            check("round_hs_valid", 32'(hs_valid), 32'(e_hv));
            check("round_new_hs", 32'(new_hs), 32'(e_nhs));
            check("round_pd_count", 32'(pd_cnt - pd0), 32'(e_pd));
            check("round_fs_count", 32'(fs_cnt - fs0), 32'(e_fs));
            check("round_to_count", 32'(to_cnt - to0), 32'(e_to));
            if (e_pd == 1)
                check("press_latency_ok", 32'(lat >= 3 && lat <= 5), 32'd1);
        end
        state = 2'd0;
        tick(1);
        if (lit) check("new_hs_after_exit", 32'(new_hs), 32'd0);
        tick(3);
    endtask

    initial begin
        int to0;
        tick(3);
        check("rst_press_done", 32'(press_done), 32'd0);
        check("rst_last_time", 32'(last_time), 32'd0);
        check("rst_best_time", 32'(best_time), 32'd0);
        check("rst_hs_valid", 32'(hs_valid), 32'd0);
        check("rst_new_hs", 32'(new_hs), 32'd0);
        iRST_N = 1'b1;
        cmp_en = 1'b1;
        tick(2);

        // d cycles after entry -> captured ms = (d+1)/4
        round(40, 0, 0, 60, 1, 10, 10, 1, 1, 1, 0, 0);
        round(28, 0, 0, 50, 1, 7, 7, 1, 1, 1, 0, 0);
        round(28, 0, 0, 50, 1, 7, 7, 1, 0, 1, 0, 0);
        round(12, 1, 0, 30, 1, 3, 7, 1, 0, 1, 1, 0);
        round(90, 0, 0, 100, 1, 20, 7, 1, 0, 0, 0, 1);
        round(20, 0, 1, 40, 1, 5, 0, 0, 0, 1, 0, 0);
        round(60, 0, 0, 80, 1, 15, 15, 1, 1, 1, 0, 0);

        // Reset in the middle of state 2
        state = 2'd1; tick(6);
        state = 2'd2; tick(24);
        to0 = to_cnt;
        iRST_N = 1'b0; tick(1); iRST_N = 1'b1;
        check("midrst_last", 32'(last_time), 32'd0);
        check("midrst_best", 32'(best_time), 32'd0);
        check("midrst_hs_valid", 32'(hs_valid), 32'd0);
        tick(20);
        check("midrst_no_timeout", 32'(to_cnt - to0), 32'd0);
        state = 2'd0; tick(4);

        for (int r = 0; r < 30; r++)
            round($urandom_range(0, 100), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  110, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) btn_n = ~btn_n;
            clr_hs = ($urandom_range(0, 49) == 0);
            iRST_N = ($urandom_range(0, 499) != 0);
            tick(1);
        end
        iRST_N = 1'b1; clr_hs = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
